haar_dwt_stream: RTL and testbench

HAAR_DWT_STREAM -- requirements
Module: haar_dwt_stream

---
 rtl/haar_dwt_stream.sv | 205 ++++++++++++++++++++
 tb/tb_haar_dwt_stream.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/haar_dwt_stream.sv
// Streaming one-level Haar wavelet transform over a raster-order image.
// Mode 0 produces a horizontal 1-D transform per pixel pair.
// Mode 1 produces a 2-D transform per 2x2 block. Row sums and differences
// from even rows are held in a line buffer until the matching odd row arrives.
module haar_dwt_stream #(
    parameter int WIDTH  = 20,
    parameter int HEIGHT = 30,
    parameter int CH     = 3,
    parameter int DW     = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   start,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CH*DW-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH*(DW+2)-1:0]   out_ll,
    output logic [CH*(DW+2)-1:0]   out_lh,
    output logic [CH*(DW+2)-1:0]   out_hl,
    output logic [CH*(DW+2)-1:0]   out_hh,
    output logic [15:0]            out_row,
    output logic [15:0]            out_col,
    output logic                   busy,
    output logic                   done
);

    localparam int CW    = DW + 2;
    localparam int PAIRS = WIDTH / 2;
    localparam int IW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ROW_EVEN = 2'd1;
    localparam logic [1:0] ROW_ODD  = 2'd2;
    localparam logic [1:0] DRAIN    = 2'd3;

    logic [1:0]          state;
    logic                mode_r;
    logic [15:0]         col;
    logic [15:0]         row;
    logic [CH*DW-1:0]    a_reg;
    logic [CH*CW-1:0]    sbuf [PAIRS];
    logic [CH*CW-1:0]    dbuf [PAIRS];
    logic [IW-1:0]       pidx;

    logic                in_fire;
    logic                pair_done;
    logic                last_col;
    logic                last_row;
    logic                emit;
    logic                buf_write;

    logic [CH*CW-1:0]    nxt_ll, nxt_lh, nxt_hl, nxt_hh, nxt_s, nxt_d;
    logic signed [CW-1:0] sum_t, dif_t, bs_t, bd_t, half_s, half_d;
    logic signed [CW:0]   sum_x, dif_x, bs_x, bd_x, t_ll, t_lh, t_hl, t_hh;

    assign in_ready  = ((state == ROW_EVEN) || (state == ROW_ODD)) && (!out_valid || out_ready);
    assign busy      = (state != IDLE);
    assign in_fire   = in_valid && in_ready;
    assign pair_done = in_fire && col[0];
    assign last_col  = (col == 16'(WIDTH - 1));
    assign last_row  = (row == 16'(HEIGHT - 1));
    assign emit      = pair_done && (!mode_r || (state == ROW_ODD));
    assign buf_write = pair_done && mode_r && (state == ROW_EVEN);
    assign pidx      = IW'(col >> 1);

    // Per-channel coefficient arithmetic for the pair completing this cycle
    always_comb begin
        nxt_ll = '0;
        nxt_lh = '0;
        nxt_hl = '0;
        nxt_hh = '0;
        nxt_s  = '0;
        nxt_d  = '0;
        sum_t  = '0;
        dif_t  = '0;
        bs_t   = '0;
        bd_t   = '0;
        half_s = '0;
        half_d = '0;
        sum_x  = '0;
        dif_x  = '0;
        bs_x   = '0;
        bd_x   = '0;
        t_ll   = '0;
        t_lh   = '0;
        t_hl   = '0;
        t_hh   = '0;
        for (int c = 0; c < CH; c++) begin
            sum_t  = CW'(a_reg[c*DW +: DW]) + CW'(in_data[c*DW +: DW]);
            dif_t  = CW'(a_reg[c*DW +: DW]) - CW'(in_data[c*DW +: DW]);
            bs_t   = sbuf[pidx][c*CW +: CW];
            bd_t   = dbuf[pidx][c*CW +: CW];
            half_s = sum_t >>> 1;
            half_d = dif_t >>> 1;
            sum_x  = {sum_t[CW-1], sum_t};
            dif_x  = {dif_t[CW-1], dif_t};
            bs_x   = {bs_t[CW-1], bs_t};
            bd_x   = {bd_t[CW-1], bd_t};
            t_ll   = (bs_x + sum_x) >>> 2;
            t_lh   = (bs_x - sum_x) >>> 2;
            t_hl   = (bd_x + dif_x) >>> 2;
            t_hh   = (bd_x - dif_x) >>> 2;
            nxt_s[c*CW +: CW] = sum_t;
            nxt_d[c*CW +: CW] = dif_t;
            if (mode_r) begin
                nxt_ll[c*CW +: CW] = t_ll[CW-1:0];
                nxt_lh[c*CW +: CW] = t_lh[CW-1:0];
                nxt_hl[c*CW +: CW] = t_hl[CW-1:0];
                nxt_hh[c*CW +: CW] = t_hh[CW-1:0];
            end else begin
                nxt_ll[c*CW +: CW] = half_s;
                nxt_hl[c*CW +: CW] = half_d;
            end
        end
    end

    // Frame sequencing: state, latched mode, raster counters and done pulse
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state  <= IDLE;
            mode_r <= 1'b0;
            col    <= '0;
            row    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ROW_EVEN;
                        mode_r <= mode;
                        col    <= '0;
                        row    <= '0;
                    end
                end
                ROW_EVEN, ROW_ODD: begin
                    if (in_fire) begin
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                state <= DRAIN;
                            end else begin
                                row   <= row + 16'd1;
                                state <= (mode_r && (state == ROW_EVEN)) ? ROW_ODD : ROW_EVEN;
                            end
                        end else begin
                            col <= col + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid || out_ready) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Hold the even-column pixel until its odd partner arrives
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_reg <= '0;
        end else if (in_fire && !col[0]) begin
            a_reg <= in_data;
        end
    end

    // Even-row sums and differences wait here for the odd row below them
    always_ff @(posedge HCLK) begin
        if (buf_write) begin
            sbuf[pidx] <= nxt_s;
            dbuf[pidx] <= nxt_d;
        end
    end

    // Output register: loads on pair completion, holds until accepted downstream
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            out_valid <= 1'b0;
            out_ll    <= '0;
            out_lh    <= '0;
            out_hl    <= '0;
            out_hh    <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_ll    <= nxt_ll;
            out_lh    <= nxt_lh;
            out_hl    <= nxt_hl;
            out_hh    <= nxt_hh;
            out_row   <= mode_r ? (row >> 1) : row;
            out_col   <= col >> 1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_haar_dwt_stream.sv
// Bench for haar_dwt_stream at default parameters (20x30, 3 channels, 8 bits).
// Each frame's expected coefficients come from block-sum formulas over the
// pixel array and are compared in order against every output handshake.
module tb_haar_dwt_stream;

    localparam int W  = 20;
    localparam int H  = 30;
    localparam int CH = 3;
    localparam int DW = 8;
    localparam int CW = DW + 2;

    logic                HCLK;
    logic                HRESET;
    logic                start;
    logic                mode;
    logic                in_valid;
    logic                in_ready;
    logic [CH*DW-1:0]    in_data;
    logic                out_valid;
    logic                out_ready;
    logic [CH*CW-1:0]    out_ll, out_lh, out_hl, out_hh;
    logic [15:0]         out_row, out_col;
    logic                busy;
    logic                done;

    typedef struct {
        logic [CH*CW-1:0] ll;
        logic [CH*CW-1:0] lh;
        logic [CH*CW-1:0] hl;
        logic [CH*CW-1:0] hh;
        logic [15:0]      row;
        logic [15:0]      col;
    } coef_t;

    logic [CH*DW-1:0] pix [H][W];
    coef_t            exp_q [$];
    coef_t            recv_q [$];
    int               err_count;
    int               check_count;

    haar_dwt_stream #(.WIDTH(W), .HEIGHT(H), .CH(CH), .DW(DW)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ll    (out_ll),
        .out_lh    (out_lh),
        .out_hl    (out_hl),
        .out_hh    (out_hh),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
        check_count++;
        if (got !== expv) begin
            err_count++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [63:0] fld(input logic [CH*CW-1:0] v, input int c);
        logic [CW-1:0] t;
        t = v[c*CW +: CW];
        return 64'(t);
    endfunction

    function automatic logic [63:0] sx(input int v);
        logic [CW-1:0] t;
        t = CW'(v);
        return 64'(t);
    endfunction

    function automatic logic [CH*DW-1:0] rep(input int v);
        logic [DW-1:0] t;
        t = DW'(v);
        return {CH{t}};
    endfunction

    task automatic fillRandom();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                pix[r][c] = (CH*DW)'($urandom);
    endtask

    // Expected coefficients straight from the transform definitions
    task automatic buildExpected(input bit m);
        coef_t e;
        int a, b, cc, d;
        exp_q.delete();
        if (!m) begin
            for (int r = 0; r < H; r++) begin
                for (int p = 0; p < W/2; p++) begin
                    e = '{default: '0};
                    for (int c = 0; c < CH; c++) begin
                        a = int'(pix[r][2*p][c*DW +: DW]);
                        b = int'(pix[r][2*p+1][c*DW +: DW]);
                        e.ll[c*CW +: CW] = CW'((a + b) >>> 1);
                        e.hl[c*CW +: CW] = CW'((a - b) >>> 1);
                    end
                    e.row = 16'(r);
                    e.col = 16'(p);
                    exp_q.push_back(e);
                end
            end
        end else begin
            for (int rp = 0; rp < H/2; rp++) begin
                for (int p = 0; p < W/2; p++) begin
                    e = '{default: '0};
                    for (int c = 0; c < CH; c++) begin
                        a  = int'(pix[2*rp][2*p][c*DW +: DW]);
                        b  = int'(pix[2*rp][2*p+1][c*DW +: DW]);
                        cc = int'(pix[2*rp+1][2*p][c*DW +: DW]);
                        d  = int'(pix[2*rp+1][2*p+1][c*DW +: DW]);
                        e.ll[c*CW +: CW] = CW'((a + b + cc + d) >>> 2);
                        e.lh[c*CW +: CW] = CW'(((a + b) - (cc + d)) >>> 2);
                        e.hl[c*CW +: CW] = CW'(((a - b) + (cc - d)) >>> 2);
                        e.hh[c*CW +: CW] = CW'(((a - b) - (cc - d)) >>> 2);
                    end
                    e.row = 16'(rp);
                    e.col = 16'(p);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Runs one frame; caller is positioned just after a falling edge
    task automatic applyStimulus(input bit m, input int vpct, input int rpct, input bit disturb,
                                 input int stall_len, input int abort_at);
        int    pix_idx, out_cnt, total, cyc, stall_cnt;
        bit    done_due, running, aborted, stalled;
        logic [CH*CW-1:0] snap_ll, snap_hl;
        coef_t e;
        buildExpected(m);
        recv_q.delete();
        total = exp_q.size();
        start = 1'b1;
        mode = m;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        pix_idx = 0; out_cnt = 0; cyc = 0; stall_cnt = 0;
        done_due = 0; running = 1; aborted = 0;
        snap_ll = '0; snap_hl = '0;
        while (running) begin
            if (abort_at >= 0 && pix_idx >= abort_at) begin
                HRESET = 1'b1;
                #1;
                checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
                checkOutput("rst_out_ll", 64'(out_ll), 64'd0);
                checkOutput("rst_out_hl", 64'(out_hl), 64'd0);
                checkOutput("rst_out_row", 64'(out_row), 64'd0);
                checkOutput("rst_busy", 64'(busy), 64'd0);
                checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
                checkOutput("rst_done", 64'(done), 64'd0);
                aborted = 1;
                running = 0;
            end else if (done_due) begin
                checkOutput("done_after_last", 64'(done), 64'd1);
                checkOutput("idle_after_done", 64'(busy), 64'd0);
                running = 0;
            end else if (done) begin
                checkOutput("early_done", 64'(out_cnt), 64'(total));
                running = 0;
            end else if (cyc >= 20000) begin
                checkOutput("timeout", 64'(cyc), 64'd0);
                running = 0;
            end else begin
                in_valid = (pix_idx < W*H) && ($urandom_range(99) < vpct);
                if (pix_idx < W*H) in_data = pix[pix_idx / W][pix_idx % W];
                else in_data = '0;
                out_ready = ($urandom_range(99) < rpct);
                if (disturb) begin
                    start = ($urandom_range(3) == 0);
                    mode = 1'($urandom_range(1));
                end
                stalled = 0;
                if (stall_len > 0 && stall_cnt < stall_len && out_valid) begin
                    if (stall_cnt == 0) begin
                        snap_ll = out_ll;
                        snap_hl = out_hl;
                    end
                    out_ready = 1'b0;
                    stalled = 1;
                end
                #1;
                if (stalled) begin
                    checkOutput("stall_valid", 64'(out_valid), 64'd1);
                    checkOutput("stall_hold_ll", 64'(out_ll), 64'(snap_ll));
                    checkOutput("stall_hold_hl", 64'(out_hl), 64'(snap_hl));
                    checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
                    stall_cnt++;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("extra_output", 64'(out_cnt + 1), 64'(total));
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("ll", 64'(out_ll), 64'(e.ll));
                        checkOutput("lh", 64'(out_lh), 64'(e.lh));
                        checkOutput("hl", 64'(out_hl), 64'(e.hl));
                        checkOutput("hh", 64'(out_hh), 64'(e.hh));
                        checkOutput("row", 64'(out_row), 64'(e.row));
                        checkOutput("col", 64'(out_col), 64'(e.col));
                    end
                    recv_q.push_back('{out_ll, out_lh, out_hl, out_hh, out_row, out_col});
                    out_cnt++;
                    if (out_cnt == total) done_due = 1;
                end
                if (in_valid && in_ready) pix_idx++;
                @(negedge HCLK);
                cyc++;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        mode = 1'b0;
        if (!aborted) begin
            checkOutput("out_count", 64'(out_cnt), 64'(total));
            @(negedge HCLK);
            checkOutput("done_single", 64'(done), 64'd0);
        end
    endtask

    initial begin
        err_count = 0;
        check_count = 0;
        HRESET = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        @(negedge HCLK);
        @(negedge HCLK);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_ll", 64'(out_ll), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        HRESET = 1'b0;

        // Mode 0 with a known prefix on row 0, full throughput
        fillRandom();
        pix[0][0] = rep(10);  pix[0][1] = rep(20);
        pix[0][2] = rep(30);  pix[0][3] = rep(30);
        pix[0][4] = rep(255); pix[0][5] = rep(0);
        pix[0][6] = rep(7);   pix[0][7] = rep(8);
        applyStimulus(1'b0, 100, 100, 1'b0, 0, -1);
        if (recv_q.size() < 4) begin
            checkOutput("m0_dir_count", 64'(recv_q.size()), 64'd4);
        end else begin
            checkOutput("m0_l0", fld(recv_q[0].ll, 0), sx(15));
            checkOutput("m0_h0", fld(recv_q[0].hl, 0), sx(-5));
            checkOutput("m0_l1", fld(recv_q[1].ll, 0), sx(30));
            checkOutput("m0_h1", fld(recv_q[1].hl, 0), sx(0));
            checkOutput("m0_l2", fld(recv_q[2].ll, 0), sx(127));
            checkOutput("m0_h2", fld(recv_q[2].hl, 0), sx(127));
            checkOutput("m0_l3", fld(recv_q[3].ll, 2), sx(7));
            checkOutput("m0_h3", fld(recv_q[3].hl, 2), sx(-1));
            checkOutput("m0_lh0", fld(recv_q[3].lh, 1), sx(0));
        end

        // Mode 1 with a known first block and a 5-cycle downstream stall
        fillRandom();
        pix[0][0] = rep(10); pix[0][1] = rep(20);
        pix[1][0] = rep(30); pix[1][1] = rep(40);
        applyStimulus(1'b1, 100, 100, 1'b0, 5, -1);
        if (recv_q.size() < 1) begin
            checkOutput("m1_dir_count", 64'(recv_q.size()), 64'd1);
        end else begin
            checkOutput("m1_ll", fld(recv_q[0].ll, 0), sx(25));
            checkOutput("m1_lh", fld(recv_q[0].lh, 0), sx(-10));
            checkOutput("m1_hl", fld(recv_q[0].hl, 0), sx(-5));
            checkOutput("m1_hh", fld(recv_q[0].hh, 0), sx(0));
            checkOutput("m1_row", 64'(recv_q[0].row), 64'd0);
            checkOutput("m1_col", 64'(recv_q[0].col), 64'd0);
        end

        // Spurious start pulses and mode toggles during busy frames
        fillRandom();
        applyStimulus(1'b1, 70, 60, 1'b1, 0, -1);
        fillRandom();
        applyStimulus(1'b0, 80, 50, 1'b1, 0, -1);

        // Reset in the middle of row 1, then a clean frame right after release
        fillRandom();
        applyStimulus(1'b0, 100, 100, 1'b0, 0, W + 5);
        @(negedge HCLK);
        checkOutput("no_done_in_reset", 64'(done), 64'd0);
        HRESET = 1'b0;
        applyStimulus(1'b0, 100, 100, 1'b0, 0, -1);

        // Mode 1 with heavy random back-pressure and gaps
        fillRandom();
        applyStimulus(1'b1, 50, 50, 1'b0, 0, -1);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
